dm_cache_ctrl: RTL and testbench

//  Parametrised direct-mapped cache: CPU valid/ready request port, line-wide memory port with

---
 rtl/dm_cache_pkg.sv | 25 ++
 rtl/dm_cache_tag_array.sv | 34 +++
 rtl/dm_cache_ctrl.sv | 121 ++++++++++++
 tb/tb_dm_cache_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_cache_pkg.sv
// dm_cache_pkg: FSM state codes and address-field width helpers for the direct-mapped cache
package dm_cache_pkg;
  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_LOOKUP      = 3'd1;
  localparam logic [2:0] S_EVICT       = 3'd2;
  localparam logic [2:0] S_REFILL_REQ  = 3'd3;
  localparam logic [2:0] S_REFILL_WAIT = 3'd4;
  localparam logic [2:0] S_WT_WRITE    = 3'd5;
  localparam logic [2:0] S_RESP        = 3'd6;
  function automatic int byte_w(int data_w);
    return $clog2(data_w / 8);
  endfunction
  function automatic int offset_w(int data_w, int wpl);
    return $clog2(data_w / 8) + $clog2(wpl);
  endfunction
  function automatic int index_w(int num_lines);
    return $clog2(num_lines);
  endfunction
  function automatic int tag_w(int addr_w, int data_w, int wpl, int num_lines);
    return addr_w - offset_w(data_w, wpl) - index_w(num_lines);
  endfunction
  function automatic int line_w(int data_w, int wpl);
    return data_w * wpl;
  endfunction
endpackage

// File: rtl/dm_cache_tag_array.sv
// dm_cache_tag_array: per-line valid/dirty/tag store; every write marks the line valid
module dm_cache_tag_array
  import dm_cache_pkg::*;
#(
  parameter int IDX_W = 6,
  parameter int TAG_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic             rd_dirty,
  output logic [TAG_W-1:0] rd_tag,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_dirty,
  input  logic [TAG_W-1:0] wr_tag
);
  logic [(1<<IDX_W)-1:0] valid, dirty;
  logic [TAG_W-1:0] tags [1<<IDX_W];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid <= '0;
      dirty <= '0;
    end else if (we) begin
      valid[wr_idx] <= 1'b1;
      dirty[wr_idx] <= wr_dirty;
    end
  always_ff @(posedge clk)
    if (we) tags[wr_idx] <= wr_tag;
  assign rd_valid = valid[rd_idx];
  assign rd_dirty = dirty[rd_idx];
  assign rd_tag = tags[rd_idx];
endmodule

// File: rtl/dm_cache_ctrl.sv
// dm_cache_ctrl: direct-mapped cache with miss FSM, write-back or write-through, hit/miss counters
module dm_cache_ctrl
  import dm_cache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int WORDS_PER_LINE = 16,
  parameter int NUM_LINES = 64,
  parameter int WRITE_BACK = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             cpu_req_valid,
  output logic                             cpu_req_ready,
  input  logic                             cpu_req_we,
  input  logic [ADDR_W-1:0]                cpu_req_addr,
  input  logic [DATA_W-1:0]                cpu_req_wdata,
  output logic                             cpu_resp_valid,
  output logic [DATA_W-1:0]                cpu_resp_rdata,
  output logic                             cpu_resp_hit,
  output logic                             mem_req_valid,
  input  logic                             mem_req_ready,
  output logic                             mem_req_we,
  output logic [ADDR_W-1:0]                mem_req_addr,
  output logic [DATA_W*WORDS_PER_LINE-1:0] mem_req_wdata,
  input  logic                             mem_resp_valid,
  input  logic [DATA_W*WORDS_PER_LINE-1:0] mem_resp_rdata,
  output logic [31:0]                      hit_count,
  output logic [31:0]                      miss_count
);
  localparam int BYTE_W = byte_w(DATA_W);
  localparam int OFF_W = offset_w(DATA_W, WORDS_PER_LINE);
  localparam int WORD_W = OFF_W - BYTE_W;
  localparam int IDX_W = index_w(NUM_LINES);
  localparam int TAG_W = tag_w(ADDR_W, DATA_W, WORDS_PER_LINE, NUM_LINES);
  localparam int LW = line_w(DATA_W, WORDS_PER_LINE);
  localparam bit WB = WRITE_BACK != 0;
  logic [2:0] state, nxt;
  logic req_we, hit_r, hit, v_valid, v_dirty, tag_we, wt_store, unused_bits;
  logic [ADDR_W-1:BYTE_W] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [TAG_W-1:0] req_tag, v_tag;
  logic [IDX_W-1:0] req_idx;
  logic [WORD_W-1:0] req_word;
  logic [LW-1:0] data [NUM_LINES];
  logic [LW-1:0] line, merged, refill;
  assign unused_bits = ^cpu_req_addr[BYTE_W-1:0];
  assign req_tag = req_addr[ADDR_W-1 -: TAG_W];
  assign req_idx = req_addr[OFF_W +: IDX_W];
  assign req_word = req_addr[BYTE_W +: WORD_W];
  assign line = data[req_idx];
  assign hit = v_valid && v_tag == req_tag;
  assign wt_store = req_we && !WB;
  always_comb begin
    merged = line;
    merged[req_word*DATA_W +: DATA_W] = req_wdata;
    refill = mem_resp_rdata;
    refill[req_word*DATA_W +: DATA_W] = req_we ? req_wdata : mem_resp_rdata[req_word*DATA_W +: DATA_W];
  end
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:        nxt = cpu_req_valid ? S_LOOKUP : S_IDLE;
      S_LOOKUP:      nxt = hit ? (wt_store ? S_WT_WRITE : S_RESP)
                               : (v_valid && v_dirty && WB ? S_EVICT : S_REFILL_REQ);
      S_EVICT:       nxt = mem_req_ready ? S_REFILL_REQ : S_EVICT;
      S_REFILL_REQ:  nxt = mem_req_ready ? S_REFILL_WAIT : S_REFILL_REQ;
      S_REFILL_WAIT: nxt = mem_resp_valid ? (wt_store ? S_WT_WRITE : S_RESP) : S_REFILL_WAIT;
      S_WT_WRITE:    nxt = mem_req_ready ? S_RESP : S_WT_WRITE;
      S_RESP:        nxt = cpu_req_valid ? S_LOOKUP : S_IDLE;
      default:       nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      req_we <= 1'b0;
      req_addr <= '0;
      req_wdata <= '0;
      hit_r <= 1'b0;
      hit_count <= '0;
      miss_count <= '0;
    end else begin
      state <= nxt;
      if (cpu_req_valid && cpu_req_ready) begin
        req_we <= cpu_req_we;
        req_addr <= cpu_req_addr[ADDR_W-1:BYTE_W];
        req_wdata <= cpu_req_wdata;
      end
      if (state == S_LOOKUP) begin
        hit_r <= hit;
        hit_count <= hit && hit_count != '1 ? hit_count + 32'd1 : hit_count;
        miss_count <= !hit && miss_count != '1 ? miss_count + 32'd1 : miss_count;
      end
    end
  // data array is unreset; writes are gated by the (reset) state so an aborted refill never lands
  always_ff @(posedge clk)
    if (state == S_LOOKUP && hit && req_we) data[req_idx] <= merged;
    else if (state == S_REFILL_WAIT && mem_resp_valid) data[req_idx] <= refill;
  assign tag_we = (state == S_LOOKUP && hit && req_we && WB) || (state == S_REFILL_WAIT && mem_resp_valid);
  dm_cache_tag_array #(.IDX_W(IDX_W), .TAG_W(TAG_W)) u_tags (
    .clk(clk),
    .rst_n(rst_n),
    .rd_idx(req_idx),
    .rd_valid(v_valid),
    .rd_dirty(v_dirty),
    .rd_tag(v_tag),
    .we(tag_we),
    .wr_idx(req_idx),
    .wr_dirty(req_we && WB),
    .wr_tag(req_tag)
  );
  assign cpu_req_ready = state == S_IDLE || state == S_RESP;
  assign cpu_resp_valid = state == S_RESP;
  assign cpu_resp_hit = cpu_resp_valid && hit_r;
  assign cpu_resp_rdata = cpu_resp_valid ? line[req_word*DATA_W +: DATA_W] : '0;
  assign mem_req_valid = state == S_EVICT || state == S_REFILL_REQ || state == S_WT_WRITE;
  assign mem_req_we = state == S_EVICT || state == S_WT_WRITE;
  assign mem_req_addr = mem_req_valid ? {state == S_EVICT ? v_tag : req_tag, req_idx, {OFF_W{1'b0}}} : '0;
  assign mem_req_wdata = mem_req_we ? line : '0;
endmodule

// File: tb/tb_dm_cache_ctrl.sv
// tb_dm_cache_ctrl: directed tests of write-back and write-through instances against a line-level cache model
module tb_dm_cache_ctrl;
  typedef struct {logic we; logic [31:0] addr; logic [511:0] wdata;} mreq_t;
  logic clk = 0, rst_n = 0, sel = 0;
  logic req_valid = 0, req_we = 0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic mem_req_ready = 0, mem_resp_valid = 0;
  logic [511:0] mem_resp_rdata = '0;
  logic [1:0] rdy, rv, rh, mv, mwe;
  logic [31:0] rd [2], ma [2], hc [2], mc [2];
  logic [511:0] mwd [2];
  logic c_rdy, c_rv, c_rh, c_mv, c_mwe;
  logic [31:0] c_rd, c_ma, c_hc, c_mc;
  logic [511:0] c_mwd;
  int checks = 0, errors = 0, cyc = 0, acc_cyc = 0, hold = 0, resp_delay = 0, stab_n = 0;
  bit resp_pend = 0, exp_hit, exp_lat;
  logic [31:0] exp_rdata, last_rd, last_hc, last_mc;
  mreq_t exp_q [$], seen_q [$];
  bit mvld [64], mdty [64];
  logic [19:0] mtag [64];
  logic [511:0] mdat [64];
  logic [511:0] mm [logic [31:0]], pm [logic [31:0]];
  int unsigned m_hits, m_miss;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dm_cache_ctrl #(.WRITE_BACK(1)) u_wb (
    .clk(clk), .rst_n(rst_n), .cpu_req_valid(req_valid && !sel), .cpu_req_ready(rdy[0]),
    .cpu_req_we(req_we), .cpu_req_addr(req_addr), .cpu_req_wdata(req_wdata),
    .cpu_resp_valid(rv[0]), .cpu_resp_rdata(rd[0]), .cpu_resp_hit(rh[0]),
    .mem_req_valid(mv[0]), .mem_req_ready(mem_req_ready && !sel), .mem_req_we(mwe[0]),
    .mem_req_addr(ma[0]), .mem_req_wdata(mwd[0]), .mem_resp_valid(mem_resp_valid && !sel),
    .mem_resp_rdata(mem_resp_rdata), .hit_count(hc[0]), .miss_count(mc[0]));
  dm_cache_ctrl #(.WRITE_BACK(0)) u_wt (
    .clk(clk), .rst_n(rst_n), .cpu_req_valid(req_valid && sel), .cpu_req_ready(rdy[1]),
    .cpu_req_we(req_we), .cpu_req_addr(req_addr), .cpu_req_wdata(req_wdata),
    .cpu_resp_valid(rv[1]), .cpu_resp_rdata(rd[1]), .cpu_resp_hit(rh[1]),
    .mem_req_valid(mv[1]), .mem_req_ready(mem_req_ready && sel), .mem_req_we(mwe[1]),
    .mem_req_addr(ma[1]), .mem_req_wdata(mwd[1]), .mem_resp_valid(mem_resp_valid && sel),
    .mem_resp_rdata(mem_resp_rdata), .hit_count(hc[1]), .miss_count(mc[1]));

  assign c_rdy = rdy[sel];
  assign c_rv = rv[sel];
  assign c_rh = rh[sel];
  assign c_mv = mv[sel];
  assign c_mwe = mwe[sel];
  assign c_rd = rd[sel];
  assign c_ma = ma[sel];
  assign c_hc = hc[sel];
  assign c_mc = mc[sel];
  assign c_mwd = mwd[sel];

  task automatic chk(string n, logic [511:0] act, logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", n, act, exp);
    end
  endtask

  task automatic fail(string n);
    checks++;
    errors++;
    $display("FAIL %s", n);
  endtask

  // backing-store content of any line never written: word i of line A is 0x1000_0000 | (A + 4i)
  function automatic logic [511:0] pat(logic [31:0] la);
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = 32'h1000_0000 | (la + 32'(i * 4));
    return l;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) begin
      mvld[i] = 0;
      mdty[i] = 0;
    end
    m_hits = 0;
    m_miss = 0;
    exp_q.delete();
    mm.delete();
    pm.delete();
    resp_pend = 0;
  endfunction

  function automatic void predict(bit we, logic [31:0] a, logic [31:0] d);
    int idx = int'(a[11:6]);
    int w = int'(a[5:2]);
    logic [19:0] tg = a[31:12];
    logic [31:0] la = {a[31:6], 6'd0};
    logic [31:0] va = {mtag[idx], a[11:6], 6'd0};
    bit wb = !sel;
    bit hit = mvld[idx] && mtag[idx] == tg;
    if (hit) begin
      if (m_hits != 32'hFFFF_FFFF) m_hits++;
    end else if (m_miss != 32'hFFFF_FFFF) m_miss++;
    if (!hit) begin
      if (wb && mvld[idx] && mdty[idx]) begin
        exp_q.push_back('{1'b1, va, mdat[idx]});
        mm[va] = mdat[idx];
      end
      exp_q.push_back('{1'b0, la, '0});
      mdat[idx] = mm.exists(la) ? mm[la] : pat(la);
      mvld[idx] = 1;
      mdty[idx] = 0;
      mtag[idx] = tg;
    end
    if (we) begin
      mdat[idx][w*32 +: 32] = d;
      if (wb) mdty[idx] = 1;
      else begin
        exp_q.push_back('{1'b1, la, mdat[idx]});
        mm[la] = mdat[idx];
      end
    end
    exp_rdata = mdat[idx][w*32 +: 32];
    exp_hit = hit;
    exp_lat = hit && (wb || !we);
  endfunction

  // memory: ready after `hold` waiting cycles, read data `resp_delay` cycles after the handshake
  initial begin
    bit pv = 0, pwe = 0, rpend = 0;
    logic [31:0] pa = '0;
    logic [511:0] pwd = '0, rline = '0;
    int wcnt = 0, rcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (pv && mem_req_ready) begin
        if (pwe) pm[pa] = pwd;
        else begin
          rpend = 1;
          rcnt = resp_delay;
          rline = pm.exists(pa) ? pm[pa] : pat(pa);
        end
        wcnt = 0;
      end
      mem_resp_valid = 0;
      if (rpend) begin
        if (rcnt == 0) begin
          mem_resp_valid = 1;
          mem_resp_rdata = rline;
          rpend = 0;
        end else rcnt--;
      end
      pv = c_mv;
      pwe = c_mwe;
      pa = c_ma;
      pwd = c_mwd;
      mem_req_ready = pv && wcnt >= hold;
      if (pv && !mem_req_ready) wcnt++;
    end
  end

  // compare process: memory requests against the expected queue, responses against the model
  initial begin
    bit ppv = 0, ppr = 0, ppwe = 0;
    logic [31:0] ppa = '0;
    logic [511:0] ppwd = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) ppv = 0;
      else begin
        if (c_mv) begin
          if (exp_q.size() == 0) fail("mem_req_unexpected");
          else begin
            chk("mem_we", c_mwe, exp_q[0].we);
            chk("mem_addr", c_ma, exp_q[0].addr);
            if (exp_q[0].we) chk("mem_wdata", c_mwd, exp_q[0].wdata);
            if (mem_req_ready) begin
              seen_q.push_back('{c_mwe, c_ma, c_mwd});
              void'(exp_q.pop_front());
            end
          end
          if (ppv && !ppr) begin
            stab_n++;
            chk("mem_stable_we", c_mwe, ppwe);
            chk("mem_stable_addr", c_ma, ppa);
            chk("mem_stable_wdata", c_mwd, ppwd);
          end
        end
        ppv = c_mv;
        ppr = mem_req_ready;
        ppwe = c_mwe;
        ppa = c_ma;
        ppwd = c_mwd;
        if (c_rv) begin
          if (!resp_pend) fail("resp_unexpected");
          else begin
            chk("resp_rdata", c_rd, exp_rdata);
            chk("resp_hit", c_rh, exp_hit);
            chk("resp_hit_count", c_hc, m_hits);
            chk("resp_miss_count", c_mc, m_miss);
            chk("resp_ready", c_rdy, 1'b1);
            if (exp_lat) chk("hit_latency", cyc - acc_cyc, 2);
            last_rd = c_rd;
            last_hc = c_hc;
            last_mc = c_mc;
            resp_pend = 0;
          end
        end
      end
    end
  end

  task automatic do_reset(bit s);
    @(negedge clk);
    rst_n = 0;
    sel = s;
    req_valid = 0;
    model_reset();
    seen_q.delete();
    @(negedge clk);
    chk("rst_ready", c_rdy, 1'b1);
    chk("rst_resp_valid", c_rv, 1'b0);
    chk("rst_mem_valid", c_mv, 1'b0);
    chk("rst_rdata", c_rd, 0);
    chk("rst_counts", {c_hc, c_mc}, 0);
    rst_n = 1;
  endtask

  task automatic start(bit we, logic [31:0] a, logic [31:0] d);
    int n = 0;
    @(negedge clk);
    predict(we, a, d);
    req_valid = 1;
    req_we = we;
    req_addr = a;
    req_wdata = d;
    while (!c_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!c_rdy) fail("accept_timeout");
    acc_cyc = cyc;
    resp_pend = 1;
    @(negedge clk);
    req_valid = 0;
  endtask

  task automatic wait_resp();
    int n = 0;
    while (resp_pend && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (resp_pend) begin
      fail("resp_timeout");
      resp_pend = 0;
    end
    chk("mem_reqs_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic issue(bit we, logic [31:0] a, logic [31:0] d);
    start(we, a, d);
    wait_resp();
  endtask

  initial begin
    logic [511:0] l;
    int n;
    #2_000_000;
    $display("FAIL watchdog");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [511:0] l;
    int n;
    do_reset(0);
    issue(0, 32'h40, 0);
    chk("t1_refill_we", seen_q[$].we, 1'b0);
    chk("t1_refill_addr", seen_q[$].addr, 32'h40);
    chk("t1_rdata", last_rd, 32'h1000_0040);
    chk("t1_miss_count", last_mc, 1);
    issue(0, 32'h44, 0);
    chk("t2_rdata", last_rd, 32'h1000_0044);
    chk("t2_hit_count", last_hc, 1);
    chk("t2_no_mem", seen_q.size(), 1);
    issue(1, 32'h40, 32'hDEAD_BEEF);
    chk("t3_store_rdata", last_rd, 32'hDEAD_BEEF);
    chk("t3_store_no_mem", seen_q.size(), 1);
    hold = 5;
    issue(0, 32'h1040, 0);
    hold = 0;
    n = seen_q.size();
    l = seen_q[n-2].wdata;
    chk("t3_evict_we", seen_q[n-2].we, 1'b1);
    chk("t3_evict_addr", seen_q[n-2].addr, 32'h40);
    chk("t3_evict_word0", l[31:0], 32'hDEAD_BEEF);
    chk("t3_evict_word1", l[63:32], 32'h1000_0044);
    chk("t3_refill_addr", seen_q[n-1].addr, 32'h1040);
    chk("t3_rdata", last_rd, 32'h1000_1040);
    chk("t3_stall_seen", stab_n >= 8, 1'b1);
    @(negedge clk);
    force u_wb.hit_count = 32'hFFFF_FFFE;
    #1;
    release u_wb.hit_count;
    m_hits = 32'hFFFF_FFFE;
    issue(0, 32'h1040, 0);
    issue(0, 32'h1044, 0);
    issue(0, 32'h1048, 0);
    chk("t6_saturated", last_hc, 32'hFFFF_FFFF);
    chk("t6_rdata", last_rd, 32'h1000_1048);
    do_reset(1);
    issue(0, 32'h44, 0);
    chk("t4_load_rdata", last_rd, 32'h1000_0044);
    hold = 3;
    issue(1, 32'h44, 32'h1234_5678);
    hold = 0;
    l = seen_q[$].wdata;
    chk("t4_wt_we", seen_q[$].we, 1'b1);
    chk("t4_wt_addr", seen_q[$].addr, 32'h40);
    chk("t4_wt_word1", l[63:32], 32'h1234_5678);
    chk("t4_wt_word0", l[31:0], 32'h1000_0040);
    chk("t4_hit_count", last_hc, 1);
    issue(1, 32'h2080, 32'hCAFE_F00D);
    chk("t4_store_miss_rdata", last_rd, 32'hCAFE_F00D);
    do_reset(1);
    resp_delay = 6;
    start(0, 32'h40, 0);
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) fail("t5_refill_req_timeout");
    @(negedge clk);
    rst_n = 0;
    model_reset();
    #1;
    chk("t5_mem_valid", c_mv, 1'b0);
    chk("t5_resp_valid", c_rv, 1'b0);
    chk("t5_ready", c_rdy, 1'b1);
    @(negedge clk);
    rst_n = 1;
    resp_delay = 0;
    repeat (10) @(negedge clk);
    issue(0, 32'h40, 0);
    chk("t5_miss_count", last_mc, 1);
    chk("t5_hit_count", last_hc, 0);
    chk("t5_rdata", last_rd, 32'h1000_0040);
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
